// File: rtl/stream_merge_2_1.sv
// Registered 2:1 stream merger with a channel tag on each word. Round-robin on contention, or fixed channel-0 priority when MERGE_FIXED_PRIO_EN is defined.
// One-cycle latency. in*_ready is combinational from out_ready, with no skid buffer, and refills in the same cycle the output drains.
module stream_merge_2_1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sel
);

  logic load_en;
  logic any_valid;
  logic grant;

  assign load_en   = !out_valid || out_ready;
  assign any_valid = in0_valid || in1_valid;

`ifdef MERGE_FIXED_PRIO_EN
  assign grant = !in0_valid;
`else
  logic last_grant;

  // On contention serve the channel that did not win last; otherwise the lone requester wins.
  assign grant = (in0_valid && in1_valid) ? !last_grant : !in0_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (load_en && any_valid) begin
      last_grant <= grant;
    end
  end
`endif

  assign in0_ready = load_en && in0_valid && !grant;
  assign in1_ready = load_en && in1_valid && grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
    end else if (load_en) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= grant ? in1_data : in0_data;
        out_sel   <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_merge_2_1.sv
// Self-checking bench for stream_merge_2_1: directed scenarios plus randomized traffic against a reference model.
module tb_stream_merge_2_1;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic             in0_valid, in1_valid, in0_ready, in1_ready;
  logic             out_valid, out_ready, out_sel;

  int checks = 0;
  int errors = 0;

  // Reference model: the word the output register should hold, and who was served last.
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_sel;
  logic             m_last;
  logic             exp_r0, exp_r1;
  logic             acc0, acc1;

  always #5 clk = ~clk;

  stream_merge_2_1 #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
  );

  // Channel that should win this cycle, or -1 when nobody requests.
  function automatic int winner(input logic v0, input logic v1, input logic last);
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (!v0 && v1) return 1;
`ifdef MERGE_FIXED_PRIO_EN
    return 0;
`else
    return last ? 0 : 1;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_sel = 1'b0; m_last = 1'b1;
  endtask

  // Move to the falling edge and work out which readies the model expects.
  task automatic settle();
    int w;
    @(negedge clk);
    w = winner(in0_valid, in1_valid, m_last);
    exp_r0 = (!m_valid || out_ready) && (w == 0);
    exp_r1 = (!m_valid || out_ready) && (w == 1);
  endtask

  // Apply the clock edge to the model, then step to just after the DUT edge.
  task automatic advance();
    int   w;
    logic slot;
    slot = !m_valid || out_ready;
    w    = winner(in0_valid, in1_valid, m_last);
    acc0 = slot && (w == 0);
    acc1 = slot && (w == 1);
    if (slot) begin
      if (w >= 0) begin
        m_valid = 1'b1;
        m_data  = (w == 1) ? in1_data : in0_data;
        m_sel   = (w == 1);
        m_last  = (w == 1);
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      advance();
      if (acc0) in0_valid = 1'b0;
      if (acc1) in1_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
    if (out_sel !== 1'b0)   begin errors++; $display("FAIL reset_sel: got %b expected 0", out_sel); end
    @(posedge clk); #1 rst = 1'b0;
    // Park a word in the output register, then reset between edges.
    in0_valid = 1'b1; in0_data = 8'h77; out_ready = 1'b0;
    settle(); advance();
    in0_valid = 1'b0;
    settle();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midop_valid: got %b expected 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin errors++; $display("FAIL async_reset_data: got %h expected 00", out_data); end
    if (out_sel !== 1'b0)   begin errors++; $display("FAIL async_reset_sel: got %b expected 0", out_sel); end
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h01; in1_valid = 1'b1; in1_data = 8'h02; out_ready = 1'b1;
    settle();
    checks += 2;
    if (in0_ready !== 1'b1) begin errors++; $display("FAIL first_contention_r0: got %b expected 1", in0_ready); end
    if (in1_ready !== 1'b0) begin errors++; $display("FAIL first_contention_r1: got %b expected 0", in1_ready); end
    advance();
    if (acc0) in0_valid = 1'b0;
    if (acc1) in1_valid = 1'b0;
    flush();
  endtask

  task automatic test_single_source();
    in0_valid = 1'b1; in0_data = 8'h5A; in1_valid = 1'b0; out_ready = 1'b1;
    settle();
    checks += 2;
    if (in0_ready !== 1'b1) begin errors++; $display("FAIL single_r0: got %b expected 1", in0_ready); end
    if (in1_ready !== 1'b0) begin errors++; $display("FAIL single_r1: got %b expected 0", in1_ready); end
    advance();
    in0_valid = 1'b0;
    settle();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
    if (out_data !== 8'h5A) begin errors++; $display("FAIL single_data: got %h expected 5a", out_data); end
    if (out_sel !== 1'b0)   begin errors++; $display("FAIL single_sel: got %b expected 0", out_sel); end
    advance();
    flush();
  endtask

  task automatic test_drain();
    in1_valid = 1'b1; in1_data = 8'h33; out_ready = 1'b1;
    settle(); advance();
    in1_valid = 1'b0;
    settle();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b expected 1", out_valid); end
    if (out_data !== 8'h33) begin errors++; $display("FAIL drain_data: got %h expected 33", out_data); end
    if (out_sel !== 1'b1)   begin errors++; $display("FAIL drain_sel: got %b expected 1", out_sel); end
    advance();
    settle();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
    if (out_data !== 8'h33) begin errors++; $display("FAIL drain_hold: got %h expected 33", out_data); end
    advance();
  endtask

  task automatic test_contention();
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic [8:0] exp_q [$];
    logic [8:0] got [$];
    int ia, ib, n;
    a = '{8'h10, 8'h11, 8'h12};
    b = '{8'h20, 8'h21, 8'h22};
    ia = 0; ib = 0;
    // A lone channel-1 word first, so channel 0 is owed the next contention.
    in1_valid = 1'b1; in1_data = 8'h1F; out_ready = 1'b1;
    settle(); advance();
    in1_valid = 1'b0;
    settle(); advance();
`ifdef MERGE_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, a[i]});
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, b[i]});
`else
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, a[i]});
      exp_q.push_back({1'b1, b[i]});
    end
`endif
    n = 0;
    while (n < 30 && got.size() < 6) begin
      in0_valid = (ia < 3); if (ia < 3) in0_data = a[ia];
      in1_valid = (ib < 3); if (ib < 3) in1_data = b[ib];
      settle();
      if (out_valid) got.push_back({out_sel, out_data});
      advance();
      if (acc0) ia++;
      if (acc1) ib++;
      n++;
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
    checks += 2;
    if (got.size() != 6) begin errors++; $display("FAIL contention_count: got %0d words expected 6", got.size()); end
    if (n != 7) begin errors++; $display("FAIL contention_cycles: got %0d cycles expected 7", n); end
    for (int i = 0; i < got.size(); i++) begin
      checks += 2;
      if (got[i][7:0] !== exp_q[i][7:0]) begin
        errors++; $display("FAIL contention_data[%0d]: got %h expected %h", i, got[i][7:0], exp_q[i][7:0]);
      end
      if (got[i][8] !== exp_q[i][8]) begin
        errors++; $display("FAIL contention_sel[%0d]: got %b expected %b", i, got[i][8], exp_q[i][8]);
      end
    end
    flush();
  endtask

  task automatic test_back_pressure();
    int w;
    in0_valid = 1'b1; in0_data = 8'hAA; out_ready = 1'b0;
    settle(); advance();
    in0_valid = 1'b1; in0_data = 8'hB0; in1_valid = 1'b1; in1_data = 8'hC0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks += 4;
      if (in0_ready !== 1'b0) begin errors++; $display("FAIL stall_r0[%0d]: got %b expected 0", i, in0_ready); end
      if (in1_ready !== 1'b0) begin errors++; $display("FAIL stall_r1[%0d]: got %b expected 0", i, in1_ready); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, out_valid); end
      if (out_data !== 8'hAA) begin errors++; $display("FAIL stall_data[%0d]: got %h expected aa", i, out_data); end
      advance();
    end
`ifdef MERGE_FIXED_PRIO_EN
    w = 0;
`else
    w = 1;
`endif
    out_ready = 1'b1;
    settle();
    checks += 3;
    if (out_data !== 8'hAA) begin errors++; $display("FAIL release_data: got %h expected aa", out_data); end
    if (in0_ready !== (w == 0)) begin errors++; $display("FAIL release_r0: got %b expected %b", in0_ready, (w == 0)); end
    if (in1_ready !== (w == 1)) begin errors++; $display("FAIL release_r1: got %b expected %b", in1_ready, (w == 1)); end
    advance();
    if (acc0) in0_valid = 1'b0;
    if (acc1) in1_valid = 1'b0;
    settle();
    checks += 2;
    if (out_data !== ((w == 1) ? 8'hC0 : 8'hB0)) begin
      errors++; $display("FAIL refill_data: got %h expected %h", out_data, ((w == 1) ? 8'hC0 : 8'hB0));
    end
    if (out_sel !== w[0]) begin errors++; $display("FAIL refill_sel: got %b expected %b", out_sel, w[0]); end
    advance();
    if (acc0) in0_valid = 1'b0;
    if (acc1) in1_valid = 1'b0;
    flush();
  endtask

  task automatic test_random();
    logic [8:0] sbq [$];
    logic [8:0] head;
    for (int c = 0; c < 400; c++) begin
      if (!in0_valid && $urandom_range(0, 2) != 0) begin in0_valid = 1'b1; in0_data = 8'($urandom); end
      if (!in1_valid && $urandom_range(0, 2) != 0) begin in1_valid = 1'b1; in1_data = 8'($urandom); end
      out_ready = ($urandom_range(0, 3) != 0);
      settle();
      checks += 5;
      if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid@%0d: got %b expected %b", c, out_valid, m_valid); end
      if (out_data !== m_data)   begin errors++; $display("FAIL rand_data@%0d: got %h expected %h", c, out_data, m_data); end
      if (out_sel !== m_sel)     begin errors++; $display("FAIL rand_sel@%0d: got %b expected %b", c, out_sel, m_sel); end
      if (in0_ready !== exp_r0)  begin errors++; $display("FAIL rand_r0@%0d: got %b expected %b", c, in0_ready, exp_r0); end
      if (in1_ready !== exp_r1)  begin errors++; $display("FAIL rand_r1@%0d: got %b expected %b", c, in1_ready, exp_r1); end
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++; $display("FAIL rand_order@%0d: got %h with no word outstanding, expected none", c, out_data);
        end else begin
          head = sbq.pop_front();
          if ({out_sel, out_data} !== head) begin
            errors++; $display("FAIL rand_order@%0d: got %h expected %h", c, {out_sel, out_data}, head);
          end
        end
      end
      advance();
      if (acc0) begin sbq.push_back({1'b0, in0_data}); in0_valid = 1'b0; end
      if (acc1) begin sbq.push_back({1'b1, in1_data}); in1_valid = 1'b0; end
    end
    flush();
  endtask

  initial begin
    rst = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0;
    out_ready = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;
    exp_r0 = 1'b0; exp_r1 = 1'b0;
    model_reset();
    test_reset();
    test_single_source();
    test_drain();
    test_contention();
    test_back_pressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
